// File: rtl/tlc_pkg.sv
// Shared types and default durations for the highway/farm-road traffic light controller.
package tlc_pkg;

    typedef enum logic [2:0] {
        PH_AR0 = 3'b000,
        PH_HG  = 3'b001,
        PH_HY  = 3'b010,
        PH_AR1 = 3'b011,
        PH_FG  = 3'b100,
        PH_FY  = 3'b101
    } phase_e;

    typedef enum logic [1:0] {
        LIGHT_GREEN  = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_RED    = 2'b10
    } light_e;

    localparam int unsigned TLC_CW         = 31;
    localparam int unsigned TLC_T_ALLRED   = 50_000_000;
    localparam int unsigned TLC_T_HWY_MIN  = 1_500_000_000;
    localparam int unsigned TLC_T_YELLOW   = 150_000_000;
    localparam int unsigned TLC_T_FARM_MIN = 250_000_000;
    localparam int unsigned TLC_T_FARM_MAX = 750_000_000;
    localparam int unsigned TLC_T_FARM_GAP = 100_000_000;
    localparam int unsigned TLC_T_WALK     = 300_000_000;

    // Illegal phase codes show red on both heads.
    function automatic logic [1:0] hwy_light(input logic [2:0] ph);
        case (ph)
            PH_HG:   return LIGHT_GREEN;
            PH_HY:   return LIGHT_YELLOW;
            default: return LIGHT_RED;
        endcase
    endfunction

    function automatic logic [1:0] farm_light(input logic [2:0] ph);
        case (ph)
            PH_FG:   return LIGHT_GREEN;
            PH_FY:   return LIGHT_YELLOW;
            default: return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/tlc_sync2.sv
// Two-flop synchronizer for asynchronous detector/button inputs.
module tlc_sync2 (
    input  logic Clk,
    input  logic Rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Sensor-gated phase sequencer driving the highway and farm-road light heads.
// Optional pedestrian walk phase is built when TLC_PED_EN is defined.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int unsigned CW         = TLC_CW,
    parameter int unsigned T_ALLRED   = TLC_T_ALLRED,
    parameter int unsigned T_HWY_MIN  = TLC_T_HWY_MIN,
    parameter int unsigned T_YELLOW   = TLC_T_YELLOW,
    parameter int unsigned T_FARM_MIN = TLC_T_FARM_MIN,
    parameter int unsigned T_FARM_MAX = TLC_T_FARM_MAX,
`ifdef TLC_PED_EN
    parameter int unsigned T_FARM_GAP = TLC_T_FARM_GAP,
    parameter int unsigned T_WALK     = TLC_T_WALK
`else
    parameter int unsigned T_FARM_GAP = TLC_T_FARM_GAP
`endif
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          FarmSensor,
    output logic [1:0]    highwaySignal,
    output logic [1:0]    farmSignal,
    output logic [2:0]    phase,
    output logic [CW-1:0] Count,
`ifdef TLC_PED_EN
    output logic          PhaseStart,
    input  logic          PedReq,
    output logic          Walk
`else
    output logic          PhaseStart
`endif
);

    localparam logic [2:0] ST_AR0 = PH_AR0;
    localparam logic [2:0] ST_HG  = PH_HG;
    localparam logic [2:0] ST_HY  = PH_HY;
    localparam logic [2:0] ST_AR1 = PH_AR1;
    localparam logic [2:0] ST_FG  = PH_FG;
    localparam logic [2:0] ST_FY  = PH_FY;

    localparam logic [CW-1:0] ALLRED_LAST   = CW'(T_ALLRED - 1);
    localparam logic [CW-1:0] HWY_MIN_LAST  = CW'(T_HWY_MIN - 1);
    localparam logic [CW-1:0] YELLOW_LAST   = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] FARM_MIN_LAST = CW'(T_FARM_MIN - 1);
    localparam logic [CW-1:0] FARM_MAX_LAST = CW'(T_FARM_MAX - 1);
    localparam logic [CW-1:0] GAP_LAST      = CW'(T_FARM_GAP - 1);

    logic [2:0]    phase_q, phase_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] gap_q, gap_d, gap_now;
    logic          farm_req_q, farm_req_d;
    logic          sens_s;
    logic          serve_req;
    logic          fg_min_met;
    logic          enter_fg;

    tlc_sync2 u_sens_sync (
        .Clk      (Clk),
        .Rst      (Rst),
        .async_in (FarmSensor),
        .sync_out (sens_s)
    );

`ifdef TLC_PED_EN
    localparam logic [CW-1:0] WALK_LAST = CW'(T_WALK - 1);
    localparam logic [CW-1:0] WALK_LEN  = CW'(T_WALK);

    logic ped_s;
    logic ped_req_q, ped_req_d;
    logic walk_q, walk_d;

    tlc_sync2 u_ped_sync (
        .Clk      (Clk),
        .Rst      (Rst),
        .async_in (PedReq),
        .sync_out (ped_s)
    );

    assign serve_req  = farm_req_q | ped_req_q;
    assign fg_min_met = (count_q >= FARM_MIN_LAST) && (!walk_q || count_q >= WALK_LAST);

    // walk_q marks an FG that was entered on behalf of a pedestrian.
    always_comb begin
        ped_req_d = ped_req_q;
        walk_d    = walk_q;
        if (enter_fg) begin
            ped_req_d = 1'b0;
            walk_d    = ped_req_q;
        end else begin
            if (ped_s && phase_q != ST_FG) ped_req_d = 1'b1;
            if (phase_q != ST_FG)          walk_d    = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ped_req_q <= 1'b0;
            walk_q    <= 1'b0;
        end else begin
            ped_req_q <= ped_req_d;
            walk_q    <= walk_d;
        end
    end

    assign Walk = walk_q && (phase_q == ST_FG) && (count_q < WALK_LEN);
`else
    assign serve_req  = farm_req_q;
    assign fg_min_met = (count_q >= FARM_MIN_LAST);
`endif

    // A sensed vehicle this cycle counts as gap zero, so the gap rule sees it immediately.
    assign gap_now = sens_s ? '0 : gap_q;

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            ST_AR0: if (count_q == ALLRED_LAST) phase_d = ST_HG;
            ST_HG:  if (count_q >= HWY_MIN_LAST && serve_req) phase_d = ST_HY;
            ST_HY:  if (count_q == YELLOW_LAST) phase_d = ST_AR1;
            ST_AR1: if (count_q == ALLRED_LAST) phase_d = ST_FG;
            ST_FG:  if (count_q == FARM_MAX_LAST || (fg_min_met && gap_now >= GAP_LAST))
                        phase_d = ST_FY;
            ST_FY:  if (count_q == YELLOW_LAST) phase_d = ST_AR0;
            default: phase_d = ST_AR0;
        endcase
    end

    assign enter_fg = (phase_q == ST_AR1) && (phase_d == ST_FG);

    always_comb begin
        count_d    = '0;
        gap_d      = '0;
        farm_req_d = farm_req_q;
        if (phase_d == phase_q)
            count_d = (count_q == '1) ? count_q : count_q + CW'(1);
        if (phase_d == ST_FG && phase_q == ST_FG)
            gap_d = (gap_now == '1) ? gap_now : gap_now + CW'(1);
        if (enter_fg)
            farm_req_d = 1'b0;
        else if (sens_s && phase_q != ST_FG)
            farm_req_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            phase_q    <= ST_AR0;
            count_q    <= '0;
            gap_q      <= '0;
            farm_req_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            farm_req_q <= farm_req_d;
        end
    end

    assign highwaySignal = hwy_light(phase_q);
    assign farmSignal    = farm_light(phase_q);
    assign phase         = phase_q;
    assign Count         = count_q;
    assign PhaseStart    = (count_q == '0);

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Self-checking bench for tlc_phase_scheduler: directed scenarios plus random sensor traffic
// compared every cycle against a rule-level reference model.
module tb_tlc_phase_scheduler;

    localparam int CW         = 31;
    localparam int T_ALLRED   = 4;
    localparam int T_HWY_MIN  = 10;
    localparam int T_YELLOW   = 3;
    localparam int T_FARM_MIN = 5;
    localparam int T_FARM_MAX = 12;
    localparam int T_FARM_GAP = 3;

    localparam int P_AR0 = 0, P_HG = 1, P_HY = 2, P_AR1 = 3, P_FG = 4, P_FY = 5;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          FarmSensor = 1'b0;
    logic [1:0]    highwaySignal, farmSignal;
    logic [2:0]    phase;
    logic [CW-1:0] Count;
    logic          PhaseStart;
`ifdef TLC_PED_EN
    logic          PedReq = 1'b0;
    logic          Walk;
`endif

    tlc_phase_scheduler #(
        .CW(CW), .T_ALLRED(T_ALLRED), .T_HWY_MIN(T_HWY_MIN), .T_YELLOW(T_YELLOW),
        .T_FARM_MIN(T_FARM_MIN), .T_FARM_MAX(T_FARM_MAX), .T_FARM_GAP(T_FARM_GAP)
    ) dut (
        .Clk(Clk), .Rst(Rst), .FarmSensor(FarmSensor),
        .highwaySignal(highwaySignal), .farmSignal(farmSignal),
        .phase(phase), .Count(Count),
`ifdef TLC_PED_EN
        .PhaseStart(PhaseStart), .PedReq(PedReq), .Walk(Walk)
`else
        .PhaseStart(PhaseStart)
`endif
    );

    always #5 Clk = ~Clk;

    int checksTotal  = 0;
    int checksPassed = 0;
    int checksFailed = 0;

    // Reference model state: phase, cycles in phase, latched request, last FG cycle with a vehicle.
    int mPhase = P_AR0, mCount = 0, mLastSens = 0;
    bit mReq = 1'b0;
    bit sensHist[2] = '{1'b0, 1'b0};

    // Observed phase lengths, recorded whenever the DUT's phase output changes.
    int lastLen[8];
    logic [2:0] prevPhase = 3'b000;
    int prevCount = 0;

    function automatic logic [1:0] expHwy(input int p);
        case (p)
            P_HG:    return 2'b00;
            P_HY:    return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] expFarm(input int p);
        case (p)
            P_FG:    return 2'b00;
            P_FY:    return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else begin
            checksFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelEdge(input bit sens, input bit rst);
        bit sensS;
        bit leave;
        if (rst) begin
            mPhase = P_AR0; mCount = 0; mReq = 1'b0; mLastSens = 0;
            sensHist[0] = 1'b0; sensHist[1] = 1'b0;
            return;
        end
        sensS = sensHist[1];
        if (mPhase == P_FG && sensS) mLastSens = mCount;
        case (mPhase)
            P_AR0:   leave = (mCount == T_ALLRED - 1);
            P_HG:    leave = (mCount >= T_HWY_MIN - 1) && mReq;
            P_HY:    leave = (mCount == T_YELLOW - 1);
            P_AR1:   leave = (mCount == T_ALLRED - 1);
            P_FG:    leave = (mCount == T_FARM_MAX - 1) ||
                             (mCount >= T_FARM_MIN - 1 && (mCount - mLastSens) >= T_FARM_GAP - 1);
            default: leave = (mCount == T_YELLOW - 1);
        endcase
        if (mPhase == P_AR1 && leave) mReq = 1'b0;
        else if (sensS && mPhase != P_FG) mReq = 1'b1;
        if (leave) begin
            mPhase = (mPhase + 1) % 6;
            mCount = 0;
            mLastSens = 0;
        end else begin
            mCount++;
        end
        sensHist[1] = sensHist[0];
        sensHist[0] = sens;
    endtask

    task automatic checkOutput();
        checkValue("phase", 32'(phase), 32'(mPhase));
        checkValue("Count", 32'(Count), 32'(mCount));
        checkValue("highwaySignal", 32'(highwaySignal), 32'(expHwy(mPhase)));
        checkValue("farmSignal", 32'(farmSignal), 32'(expFarm(mPhase)));
        checkValue("PhaseStart", 32'(PhaseStart), 32'(mCount == 0));
        checkValue("farmReq", 32'(dut.farm_req_q), 32'(mReq));
    endtask

    task automatic applyStimulus(input bit sens, input bit rst);
        @(negedge Clk);
        FarmSensor = sens;
        Rst = rst;
        @(posedge Clk);
        modelEdge(sens, rst);
        #1;
        if (phase !== prevPhase) lastLen[prevPhase] = prevCount + 1;
        prevPhase = phase;
        prevCount = int'(Count);
        checkOutput();
    endtask

    task automatic runUntil(input int p, input int c, input bit sens, input int maxCycles);
        int n = 0;
        while (!(mPhase == p && mCount == c) && n < maxCycles) begin
            applyStimulus(sens, 1'b0);
            n++;
        end
        checkValue("runUntilReached", 32'(mPhase == p && mCount == c), 32'd1);
    endtask

    initial begin
        int n;
        int density;
        bit s, r;

        $display("[TB] reset and idle highway hold");
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 120; i++) applyStimulus(1'b0, 1'b0);
        checkValue("idleHoldPhase", 32'(phase), 32'(P_HG));
        checkValue("idleHoldHwy", 32'(highwaySignal), 32'd0);
        checkValue("idleHoldFarm", 32'(farmSignal), 32'd2);

        $display("[TB] one-cycle sensor pulse at HG count 2");
        applyStimulus(1'b0, 1'b1);
        runUntil(P_HG, 2, 1'b0, 50);
        applyStimulus(1'b1, 1'b0);
        runUntil(P_FG, 0, 1'b0, 50);
        checkValue("hgLen", 32'(lastLen[P_HG]), 32'd10);
        checkValue("hyLen", 32'(lastLen[P_HY]), 32'd3);
        checkValue("ar1Len", 32'(lastLen[P_AR1]), 32'd4);
        checkValue("fgEntryReq", 32'(dut.farm_req_q), 32'd0);
        runUntil(P_FY, 0, 1'b0, 50);
        checkValue("fgIdleLen", 32'(lastLen[P_FG]), 32'd5);

        $display("[TB] sensor held through FG");
        runUntil(P_HG, 0, 1'b0, 50);
        n = 0;
        while (mPhase != P_FY && n < 100) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        checkValue("heldReachedFy", 32'(mPhase), 32'(P_FY));
        checkValue("fgMaxLen", 32'(lastLen[P_FG]), 32'd12);
        runUntil(P_AR0, 0, 1'b0, 50);
        checkValue("fyLen", 32'(lastLen[P_FY]), 32'd3);

        $display("[TB] single vehicle inside FG extends green");
        runUntil(P_FG, 2, 1'b0, 100);
        applyStimulus(1'b1, 1'b0);
        runUntil(P_FY, 0, 1'b0, 50);
        checkValue("fgGapLen", 32'(lastLen[P_FG]), 32'd7);

        $display("[TB] sensor on FG entry edge");
        runUntil(P_HG, 0, 1'b0, 50);
        applyStimulus(1'b1, 1'b0);
        runUntil(P_AR1, 1, 1'b0, 50);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b0);
        checkValue("noExtraCyclePhase", 32'(phase), 32'(P_HG));
        checkValue("noExtraCycleReq", 32'(dut.farm_req_q), 32'd0);

        $display("[TB] reset in FG");
        applyStimulus(1'b1, 1'b0);
        runUntil(P_FG, 3, 1'b0, 50);
        applyStimulus(1'b0, 1'b1);
        checkValue("rstPhase", 32'(phase), 32'(P_AR0));
        checkValue("rstCount", 32'(Count), 32'd0);
        checkValue("rstHwy", 32'(highwaySignal), 32'd2);
        checkValue("rstFarm", 32'(farmSignal), 32'd2);
        checkValue("rstReq", 32'(dut.farm_req_q), 32'd0);

        $display("[TB] random sensor traffic");
        for (int blk = 0; blk < 40; blk++) begin
            density = int'($urandom_range(0, 3));
            for (int i = 0; i < 50; i++) begin
                s = ($urandom_range(0, 9) < 32'(density * 3));
                r = ($urandom_range(0, 399) == 0);
                applyStimulus(s, r);
            end
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
